// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcode/func
// constants, datapath select codes and the decoded-instruction flag set.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  localparam logic [1:0] DST_RD   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_EXT   = 2'b10;
  localparam logic [1:0] WD_PC4   = 2'b11;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
    logic jr;
    logic nop;
  } instr_t;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decode: op/func to one-hot instruction flags.
// Anything not recognised raises nop.
module mc_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output instr_t     o_instr
);

  logic w_rtype;
  logic w_known;

  assign w_rtype = (i_op == OP_RTYPE);

  always_comb begin
    o_instr      = '0;
    o_instr.addu = w_rtype && (i_func == FN_ADDU);
    o_instr.subu = w_rtype && (i_func == FN_SUBU);
    o_instr.jr   = w_rtype && (i_func == FN_JR);
    o_instr.ori  = (i_op == OP_ORI);
    o_instr.lw   = (i_op == OP_LW);
    o_instr.sw   = (i_op == OP_SW);
    o_instr.beq  = (i_op == OP_BEQ);
    o_instr.lui  = (i_op == OP_LUI);
    o_instr.jal  = (i_op == OP_JAL);
    o_instr.nop  = ~w_known;
  end

  assign w_known = (w_rtype && ((i_func == FN_ADDU) || (i_func == FN_SUBU) || (i_func == FN_JR)))
                 || (i_op == OP_ORI) || (i_op == OP_LW) || (i_op == OP_SW)
                 || (i_op == OP_BEQ) || (i_op == OP_LUI) || (i_op == OP_JAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: state register plus strobe/select logic.
// Define MC_CTRL_MEM_WAIT_EN to honour mem_ready in FETCH and MEM.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_read,
  output logic [1:0] npc_sel,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [1:0] wd_sel,
  output logic [2:0] state
);

  instr_t w_instr;
  logic   w_ready;
  state_e r_state;
  state_e w_next;

  mc_dec u_dec (
    .i_op    (op),
    .i_func  (func),
    .o_instr (w_instr)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_ready = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_ready            = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

  // Strobes are Mealy: they react to mem_ready, zero and reset in the same cycle.
  always_comb begin
    w_next    = S_FETCH;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    npc_sel   = NPC_PC4;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (w_ready) begin
          ir_wr  = 1'b1;
          pc_wr  = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_instr.jal) begin
          pc_wr     = 1'b1;
          npc_sel   = NPC_JAL;
          reg_write = 1'b1;
        end else if (w_instr.jr) begin
          pc_wr   = 1'b1;
          npc_sel = NPC_JR;
        end else if (!w_instr.nop) begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_instr.beq) begin
          pc_wr   = zero;
          npc_sel = NPC_BEQ;
        end else if (w_instr.lw || w_instr.sw) begin
          w_next = S_MEM;
        end else if (w_instr.addu || w_instr.subu || w_instr.ori || w_instr.lui) begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = w_instr.lw;
        mem_write = w_instr.sw;
        if ((w_instr.lw || w_instr.sw) && !w_ready) w_next = S_MEM;
        else if (w_instr.lw)                        w_next = S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
    if (reset) begin
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      npc_sel   = NPC_PC4;
      w_next    = S_FETCH;
    end
  end

  // Selects follow op/func directly so they stay steady across EXE, MEM and WB.
  always_comb begin
    ext_op  = EXT_SIGN;
    alu_op  = ALU_ADD;
    reg_dst = DST_RD;
    alu_src = 1'b0;
    wd_sel  = WD_ALU;
    if (w_instr.subu || w_instr.beq) alu_op = ALU_SUB;
    if (w_instr.ori) begin
      reg_dst = DST_RT;
      alu_src = 1'b1;
      ext_op  = EXT_ZERO;
      alu_op  = ALU_OR;
    end
    if (w_instr.lui) begin
      reg_dst = DST_RT;
      ext_op  = EXT_LUI;
      wd_sel  = WD_EXT;
    end
    if (w_instr.lw) begin
      reg_dst = DST_RT;
      wd_sel  = WD_MEM;
      alu_src = 1'b1;
    end
    if (w_instr.sw) alu_src = 1'b1;
    if (w_instr.jal) begin
      reg_dst = DST_RA;
      wd_sel  = WD_PC4;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction expected cycle traces checked every cycle.
module tb_mc_ctrl;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_NOP} kind_e;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       zro;
    logic [5:0] op;
    logic [5:0] fn;
    logic       chk_st;
    logic       chk_sel;
    logic [2:0] st;
    logic       pc;
    logic       ir;
    logic       rw;
    logic       mw;
    logic       mr;
    logic [1:0] npc;
    logic [1:0] ext;
    logic [2:0] alu;
    logic [1:0] dst;
    logic       src;
    logic [1:0] wd;
  } cyc_t;

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_wr, ir_wr, reg_write, mem_write, mem_read, alu_src;
  logic [1:0] npc_sel, ext_op, reg_dst, wd_sel;
  logic [2:0] alu_op, state;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_wr     (pc_wr),
    .ir_wr     (ir_wr),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .npc_sel   (npc_sel),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .wd_sel    (wd_sel),
    .state     (state)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  cyc_t exp_q[$];
  cyc_t trace[$];
  cyc_t e_cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Expected datapath selects for an instruction class, strobes all low.
  function automatic cyc_t blank(input kind_e k, input logic [5:0] o, input logic [5:0] f,
                                 input logic z);
    cyc_t c;
    c = '{default: '0};
    c.op = o; c.fn = f; c.zro = z; c.rdy = 1'b1; c.chk_st = 1'b1;
    case (k)
      K_SUBU: c.alu = 3'd1;
      K_ORI:  begin c.dst = 2'd1; c.src = 1'b1; c.ext = 2'd1; c.alu = 3'd2; end
      K_LUI:  begin c.dst = 2'd1; c.ext = 2'd2; c.wd = 2'd2; end
      K_LW:   begin c.dst = 2'd1; c.wd = 2'd1; c.src = 1'b1; end
      K_SW:   c.src = 1'b1;
      K_BEQ:  c.alu = 3'd1;
      K_JAL:  begin c.dst = 2'd2; c.wd = 2'd3; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic run(input kind_e k, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int fw, input int mw, input bit rm, input int lat);
    cyc_t c;
    int   efw;
    int   emw;
    efw = WAIT_EN ? fw : 0;
    emw = (WAIT_EN && !rm) ? mw : 0;
    trace.delete();
    for (int i = 0; i < efw; i++) begin
      c = blank(k, o, f, z); c.st = 3'd0; c.rdy = 1'b0; c.mr = 1'b1;
      trace.push_back(c);
    end
    c = blank(k, o, f, z); c.st = 3'd0; c.mr = 1'b1; c.ir = 1'b1; c.pc = 1'b1;
    c.rdy = WAIT_EN ? 1'b1 : (fw == 0);
    trace.push_back(c);
    c = blank(k, o, f, z); c.st = 3'd1; c.chk_sel = 1'b1;
    if (k == K_JAL) begin c.pc = 1'b1; c.npc = 2'd2; c.rw = 1'b1; end
    if (k == K_JR)  begin c.pc = 1'b1; c.npc = 2'd3; end
    trace.push_back(c);
    if (k != K_JAL && k != K_JR && k != K_NOP) begin
      c = blank(k, o, f, z); c.st = 3'd2; c.chk_sel = 1'b1;
      if (k == K_BEQ) begin c.pc = z; c.npc = 2'd1; end
      trace.push_back(c);
      if ((k == K_LW || k == K_SW) && rm) begin
        c = blank(k, o, f, z); c.st = 3'd3; c.rst = 1'b1;
        trace.push_back(c);
      end else begin
        if (k == K_LW || k == K_SW) begin
          for (int i = 0; i < emw; i++) begin
            c = blank(k, o, f, z); c.st = 3'd3; c.chk_sel = 1'b1; c.rdy = 1'b0;
            c.mr = (k == K_LW); c.mw = (k == K_SW);
            trace.push_back(c);
          end
          c = blank(k, o, f, z); c.st = 3'd3; c.chk_sel = 1'b1;
          c.rdy = WAIT_EN ? 1'b1 : (mw == 0);
          c.mr = (k == K_LW); c.mw = (k == K_SW);
          trace.push_back(c);
        end
        if (k != K_SW && k != K_BEQ) begin
          c = blank(k, o, f, z); c.st = 3'd4; c.chk_sel = 1'b1; c.rw = 1'b1;
          trace.push_back(c);
        end
      end
    end
    chk("latency", trace.size() - efw - emw, lat);
    foreach (trace[i]) begin
      @(posedge clk);
      #1;
      reset     = trace[i].rst;
      mem_ready = trace[i].rdy;
      zero      = trace[i].zro;
      op        = trace[i].op;
      func      = trace[i].fn;
      exp_q.push_back(trace[i]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      if (e_cur.chk_st) chk("state", state, e_cur.st);
      chk("pc_wr", pc_wr, e_cur.pc);
      chk("ir_wr", ir_wr, e_cur.ir);
      chk("reg_write", reg_write, e_cur.rw);
      chk("mem_write", mem_write, e_cur.mw);
      chk("mem_read", mem_read, e_cur.mr);
      chk("npc_sel", npc_sel, e_cur.npc);
      if (e_cur.chk_sel) begin
        chk("ext_op", ext_op, e_cur.ext);
        chk("alu_op", alu_op, e_cur.alu);
        chk("reg_dst", reg_dst, e_cur.dst);
        chk("alu_src", alu_src, e_cur.src);
        chk("wd_sel", wd_sel, e_cur.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc_t c;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      c = blank(K_NOP, 6'h00, 6'h00, 1'b0);
      c.rst = 1'b1; c.st = 3'd0;
      reset = 1'b1;
      exp_q.push_back(c);
    end
    run(K_ADDU, 6'h00, 6'h21, 1'b0, 0, 0, 1'b0, 4);
    run(K_SUBU, 6'h00, 6'h23, 1'b0, 0, 0, 1'b0, 4);
    run(K_ORI,  6'h0D, 6'h15, 1'b0, 0, 0, 1'b0, 4);
    run(K_LUI,  6'h0F, 6'h00, 1'b0, 0, 0, 1'b0, 4);
    run(K_LW,   6'h23, 6'h00, 1'b0, 0, 2, 1'b0, 5);
    run(K_SW,   6'h2B, 6'h00, 1'b0, 1, 1, 1'b0, 4);
    run(K_BEQ,  6'h04, 6'h00, 1'b1, 0, 0, 1'b0, 3);
    run(K_BEQ,  6'h04, 6'h00, 1'b0, 0, 0, 1'b0, 3);
    run(K_JAL,  6'h03, 6'h00, 1'b0, 0, 0, 1'b0, 2);
    run(K_JR,   6'h00, 6'h08, 1'b0, 0, 0, 1'b0, 2);
    run(K_NOP,  6'h3F, 6'h00, 1'b0, 0, 0, 1'b0, 2);
    run(K_NOP,  6'h00, 6'h00, 1'b0, 0, 0, 1'b0, 2);
    run(K_SW,   6'h2B, 6'h00, 1'b0, 0, 0, 1'b1, 4);
    run(K_ADDU, 6'h00, 6'h21, 1'b0, 2, 0, 1'b0, 4);
    run(K_LW,   6'h23, 6'h00, 1'b0, 0, 0, 1'b0, 5);
    run(K_BEQ,  6'h04, 6'h00, 1'b1, 1, 0, 1'b0, 3);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 op  in  6  opcode field of the instruction register (stable from DECODE to return to FETCH).
REQ-004 func  in  6  function field of the instruction register.
REQ-005 zero  in  1  ALU equality flag (rs == rt), valid in EXE.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 pc_wr, ir_wr, reg_write, mem_write, mem_read  out  1 each  write/read strobes, active high.
REQ-008 npc_sel  out  2  00 PC+4, 01 beq target, 10 jal target, 11 rs (jr).
REQ-009 ext_op  out  2  00 sign, 01 zero, 10 lui shift.
REQ-010 alu_op  out  3  000 add, 001 sub, 010 or.
REQ-011 reg_dst  out  2  00 rd, 01 rt, 10 $31.
REQ-012 alu_src  out  1  0 register, 1 extended immediate.
REQ-013 wd_sel  out  2  00 ALU, 01 memory, 10 extender, 11 PC+4.
REQ-014 state  out  3  current state, for debug/verification.

Function
REQ-015 Supported instructions SHALL be addu, subu, ori, lw, sw, beq, lui, jal, jr; any other op/func is a NOP.
REQ-016 States SHALL be FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
REQ-017 FETCH: mem_read=1, and if mem_ready then ir_wr=1, pc_wr=1, npc_sel=00, next DECODE; otherwise hold FETCH with all strobes except mem_read at 0.
REQ-018 DECODE jal: pc_wr=1, npc_sel=10, reg_write=1, reg_dst=10, wd_sel=11, next FETCH.
REQ-019 DECODE jr: pc_wr=1, npc_sel=11, next FETCH.
REQ-020 DECODE NOP: no strobes, next FETCH; all other supported instructions next EXE.
REQ-021 EXE beq: alu_op=001, alu_src=0, pc_wr=zero, npc_sel=01, next FETCH.
REQ-022 EXE lw/sw: alu_op=000, alu_src=1, ext_op=00, next MEM; addu/subu/ori/lui: next WB.
REQ-023 MEM: sw asserts mem_write, lw asserts mem_read; both held until mem_ready; on mem_ready sw goes to FETCH and lw goes to WB.
REQ-024 WB: reg_write=1 for one cycle, next FETCH.
- addu: reg_dst=00, wd_sel=00, alu_op=000.
- subu: alu_op=001.
- ori: reg_dst=01, alu_src=1, ext_op=01, alu_op=010.
- lui: reg_dst=01, ext_op=10, wd_sel=10.
- lw: reg_dst=01, wd_sel=01.
REQ-025 Datapath selects (alu_op, alu_src, ext_op, reg_dst, wd_sel) SHALL be driven from op/func in every state from DECODE onward, so that values are stable across EXE, MEM and WB.
REQ-026 Latency with mem_ready=1 SHALL be: jal/jr/NOP 2 cycles, beq 3, sw and R-type/ori/lui 4, lw 5.
REQ-027 Each strobe SHALL assert for exactly one cycle per state visit, except in the wait states of REQ-017 and REQ-023.
REQ-028 Unused state encodings 5-7 SHALL force all strobes to 0 and go to FETCH next cycle.

Reset
REQ-029 While reset=1 all strobes SHALL be 0 and state SHALL load FETCH; the first fetch strobes SHALL occur in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobe in that cycle.

Configuration
REQ-031 With MC_CTRL_MEM_WAIT_EN defined, the wait behaviour of REQ-017 and REQ-023 applies.
REQ-032 Without MC_CTRL_MEM_WAIT_EN, mem_ready SHALL be ignored and treated as 1, so FETCH and MEM always last one cycle.

Structure
REQ-033 Package mc_ctrl_pkg SHALL hold the state encodings, the opcode/func constants and the npc_sel/ext_op/alu_op/reg_dst/wd_sel encodings.
REQ-034 Sub-module mc_dec SHALL perform the combinational instruction decode into one-hot instruction flags; mc_ctrl contains the state register and the output logic.

Verification
REQ-035 addu (op=0, func=0x21), mem_ready=1 -> states 0,1,2,4; reg_write=1 only in WB with reg_dst=00, wd_sel=00.
REQ-036 lw (op=0x23) with mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles, mem_read held high, then WB with wd_sel=01; without the macro, 5 cycles total.
REQ-037 beq (op=0x04): zero=1 -> pc_wr=1 and npc_sel=01 in EXE; zero=0 -> pc_wr=0; both return to FETCH after 3 cycles.
REQ-038 jal (op=0x03) -> DECODE has pc_wr=1, npc_sel=10, reg_write=1, reg_dst=10, wd_sel=11; jr (op=0, func=0x08) -> pc_wr=1, npc_sel=11.
REQ-039 Undefined op=0x3F -> 2-cycle NOP with no reg_write or mem_write.
REQ-040 reset pulsed during MEM of sw -> mem_write=0 in the reset cycle, state=0 the next cycle.
